// File: rtl/reg_file_wr_arbiter.sv
// Write-port owner for the register file: clears every register after reset,
// then shares the single write port between NUM_REQ requesters round-robin.
module reg_file_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_REGS   = 8,
  parameter int ADR_WIDTH  = $clog2(NUM_REGS),
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          wen_o,
  output logic [ADR_WIDTH-1:0]          wa_o,
  output logic [DATA_WIDTH-1:0]         write_data_o,
  output logic [ID_WIDTH-1:0]           grant_id_o,
  output logic                          init_done_o
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_e;

  state_e                  state_r, state_nxt_s;
  logic [ADR_WIDTH-1:0]    cnt_r, cnt_nxt_s;
  logic [ID_WIDTH-1:0]     ptr_r, ptr_nxt_s;
  logic                    wen_r, wen_nxt_s;
  logic [ADR_WIDTH-1:0]    wa_r, wa_nxt_s;
  logic [DATA_WIDTH-1:0]   wd_r, wd_nxt_s;
  logic [ID_WIDTH-1:0]     gid_r, gid_nxt_s;
  logic                    done_r, done_nxt_s;

  logic                    hit_s;
  logic [ID_WIDTH-1:0]     gnt_id_s;
  logic [NUM_REQ-1:0]      ready_s;

  // Round-robin search: first valid requester at or above the priority pointer.
  always_comb begin
    hit_s    = 1'b0;
    gnt_id_s = '0;
    ready_s  = '0;
    if (state_r == ST_ARB) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!hit_s && req_valid_i[(int'(ptr_r) + i) % NUM_REQ]) begin
          hit_s    = 1'b1;
          gnt_id_s = ID_WIDTH'((int'(ptr_r) + i) % NUM_REQ);
        end else begin
          hit_s = hit_s;
        end
      end
    end else begin
      hit_s = 1'b0;
    end
    if (hit_s) begin
      ready_s[gnt_id_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Next-state and next-output logic for the clear sequence and arbitration.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ptr_nxt_s   = ptr_r;
    wen_nxt_s   = 1'b0;
    wa_nxt_s    = wa_r;
    wd_nxt_s    = wd_r;
    gid_nxt_s   = gid_r;
    done_nxt_s  = done_r;
    case (state_r)
      ST_INIT: begin
        wen_nxt_s = 1'b1;
        wa_nxt_s  = cnt_r;
        wd_nxt_s  = '0;
        cnt_nxt_s = cnt_r + ADR_WIDTH'(1);
        if (cnt_r == ADR_WIDTH'(NUM_REGS - 1)) begin
          state_nxt_s = ST_ARB;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_ARB: begin
        if (hit_s) begin
          wen_nxt_s = 1'b1;
          wa_nxt_s  = req_addr_i[int'(gnt_id_s)*ADR_WIDTH +: ADR_WIDTH];
          wd_nxt_s  = req_data_i[int'(gnt_id_s)*DATA_WIDTH +: DATA_WIDTH];
          gid_nxt_s = gnt_id_s;
          // Wrap explicitly so non-power-of-2 NUM_REQ never points past the last requester.
          if (gnt_id_s == ID_WIDTH'(NUM_REQ - 1)) begin
            ptr_nxt_s = '0;
          end else begin
            ptr_nxt_s = gnt_id_s + ID_WIDTH'(1);
          end
        end else begin
          wen_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State and output registers; reset discards any pending write.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_INIT;
      cnt_r   <= '0;
      ptr_r   <= '0;
      wen_r   <= 1'b0;
      wa_r    <= '0;
      wd_r    <= '0;
      gid_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ptr_r   <= ptr_nxt_s;
      wen_r   <= wen_nxt_s;
      wa_r    <= wa_nxt_s;
      wd_r    <= wd_nxt_s;
      gid_r   <= gid_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign req_ready_o  = ready_s;
  assign wen_o        = wen_r;
  assign wa_o         = wa_r;
  assign write_data_o = wd_r;
  assign grant_id_o   = gid_r;
  assign init_done_o  = done_r;

endmodule
